// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the on-chip memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF  = 10;
  localparam int DATA_W_DEF  = 32;
  localparam int BURST_W_DEF = 5;

  localparam logic [DATA_W_DEF/8-1:0] BYTE_EN_ALL = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  typedef enum logic {
    OWN_DISP = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_burst_ctr.sv
// Beat sequencer for display bursts: word-address incrementer plus remaining-beat
// down-counter. Advances once per cycle unless held; flags the final beat.
module mem_arb_burst_ctr
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic [BURST_W-1:0] i_len,
  input  logic               i_hold,
  output logic [ADDR_W-1:0]  o_addr,
  output logic               o_last
);

  logic [ADDR_W-1:0]  r_addr;
  logic [BURST_W-1:0] r_remaining;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr      <= '0;
      r_remaining <= '0;
    end else if (i_load) begin
      r_addr      <= i_addr;
      r_remaining <= (i_len == '0) ? BURST_W'(1) : i_len;
    end else if (!i_hold && r_remaining != '0) begin
      r_addr      <= r_addr + ADDR_W'(1);  // wraps naturally at 2^ADDR_W
      r_remaining <= r_remaining - BURST_W'(1);
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_remaining == BURST_W'(1));

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares a single-port on-chip memory between display-fetch bursts and a host
// Avalon-MM port. Define MEM_ARB_HOST_SLOT_EN to let the host steal periodic burst slots.
module onchip_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W           = ADDR_W_DEF,
  parameter int DATA_W           = DATA_W_DEF,
  parameter int BURST_W          = BURST_W_DEF,
  parameter int HOST_SLOT_PERIOD = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                disp_burst_req,
  input  logic [ADDR_W-1:0]   disp_burst_addr,
  input  logic [BURST_W-1:0]  disp_burst_len,
  output logic                disp_burst_ack,
  output logic                disp_busy,
  output logic [DATA_W-1:0]   disp_readdata,
  output logic                disp_readdatavalid,
  input  logic [ADDR_W-1:0]   host_address,
  input  logic [DATA_W/8-1:0] host_byteenable,
  input  logic                host_read,
  input  logic                host_write,
  input  logic [DATA_W-1:0]   host_writedata,
  output logic                host_waitrequest,
  output logic [DATA_W-1:0]   host_readdata,
  output logic                host_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic                mem_clken,
  output logic [DATA_W-1:0]   mem_writedata,
  input  logic [DATA_W-1:0]   mem_readdata
);

  state_e            r_state, w_state_nxt;
  owner_e            r_rd_owner;
  logic              r_rd_valid;
  logic              w_host_strobe, w_load, w_beat, w_host_grant, w_last, w_slot;
  logic [ADDR_W-1:0] w_beat_addr;

  assign w_host_strobe = host_read | host_write;

  mem_arb_burst_ctr #(
    .ADDR_W  (ADDR_W),
    .BURST_W (BURST_W)
  ) u_burst_ctr (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_addr  (disp_burst_addr),
    .i_len   (disp_burst_len),
    .i_hold  (!w_beat),
    .o_addr  (w_beat_addr),
    .o_last  (w_last)
  );

`ifdef MEM_ARB_HOST_SLOT_EN
  localparam int PER_W = $clog2(HOST_SLOT_PERIOD + 1);
  logic [PER_W-1:0] r_period;

  assign w_slot = (r_state == BURST) && w_host_strobe && (r_period == PER_W'(HOST_SLOT_PERIOD));

  // Counts consecutive beats issued while a host strobe waits.
  always_ff @(posedge clk) begin
    if (reset || w_slot || r_state != BURST || (w_beat && w_last)) begin
      r_period <= '0;
    end else if (w_beat) begin
      r_period <= w_host_strobe ? r_period + PER_W'(1) : '0;
    end
  end
`else
  assign w_slot = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_load         = 1'b0;
    w_beat         = 1'b0;
    w_host_grant   = 1'b0;
    mem_address    = host_address;
    mem_byteenable = host_byteenable;
    mem_writedata  = host_writedata;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    if (!reset) begin
      case (r_state)
        IDLE: begin
          if (disp_burst_req) begin
            w_load      = 1'b1;
            w_state_nxt = BURST;
          end else if (w_host_strobe) begin
            w_host_grant = 1'b1;
          end
        end
        BURST: begin
          if (w_slot) begin
            w_host_grant = 1'b1;
          end else begin
            w_beat = 1'b1;
            if (w_last) w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
    if (w_beat) begin
      mem_address    = w_beat_addr;
      mem_byteenable = BYTE_EN_ALL;
      mem_chipselect = 1'b1;
    end else if (w_host_grant) begin
      mem_chipselect = 1'b1;
      mem_write      = host_write;
    end
  end

  // Tag each issued read so the returning word reaches only its requester.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_owner <= OWN_DISP;
    end else begin
      r_rd_valid <= mem_chipselect & ~mem_write;
      r_rd_owner <= w_beat ? OWN_DISP : OWN_HOST;
    end
  end

  assign mem_clken          = ~reset;
  assign host_waitrequest   = ~w_host_grant;
  assign disp_burst_ack     = w_load;
  assign disp_busy          = w_load | (~reset & (r_state == BURST));
  assign disp_readdata      = mem_readdata;
  assign host_readdata      = mem_readdata;
  assign disp_readdatavalid = ~reset & r_rd_valid & (r_rd_owner == OWN_DISP);
  assign host_readdatavalid = ~reset & r_rd_valid & (r_rd_owner == OWN_HOST);

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Scoreboard bench for onchip_mem_arbiter with a behavioural 1024x32 memory.
module tb_onchip_mem_arbiter;

  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int BW  = 5;
  localparam int BEW = DW / 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          disp_burst_req = 1'b0;
  logic [AW-1:0] disp_burst_addr = '0;
  logic [BW-1:0] disp_burst_len = '0;
  logic          disp_burst_ack, disp_busy, disp_readdatavalid;
  logic [DW-1:0] disp_readdata;
  logic [AW-1:0] host_address = '0;
  logic [BEW-1:0] host_byteenable = '0;
  logic          host_read = 1'b0, host_write = 1'b0;
  logic [DW-1:0] host_writedata = '0;
  logic          host_waitrequest, host_readdatavalid;
  logic [DW-1:0] host_readdata;
  logic [AW-1:0] mem_address;
  logic [BEW-1:0] mem_byteenable;
  logic          mem_chipselect, mem_write, mem_clken;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata = '0;

  logic [DW-1:0] mem   [0:1023];
  logic [DW-1:0] model [0:1023];
  logic [DW-1:0] host_q[$];
  logic [DW-1:0] disp_q[$];
  int checks = 0;
  int errors = 0;

  onchip_mem_arbiter dut (
    .clk                (clk),
    .reset              (reset),
    .disp_burst_req     (disp_burst_req),
    .disp_burst_addr    (disp_burst_addr),
    .disp_burst_len     (disp_burst_len),
    .disp_burst_ack     (disp_burst_ack),
    .disp_busy          (disp_busy),
    .disp_readdata      (disp_readdata),
    .disp_readdatavalid (disp_readdatavalid),
    .host_address       (host_address),
    .host_byteenable    (host_byteenable),
    .host_read          (host_read),
    .host_write         (host_write),
    .host_writedata     (host_writedata),
    .host_waitrequest   (host_waitrequest),
    .host_readdata      (host_readdata),
    .host_readdatavalid (host_readdatavalid),
    .mem_address        (mem_address),
    .mem_byteenable     (mem_byteenable),
    .mem_chipselect     (mem_chipselect),
    .mem_write          (mem_write),
    .mem_clken          (mem_clken),
    .mem_writedata      (mem_writedata),
    .mem_readdata       (mem_readdata)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE0000 ^ (i * 32'h00010003);
  end

  // Single-port synchronous memory: read data one cycle after the address.
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < BEW; b++)
          if (mem_byteenable[b]) mem[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end else begin
        mem_readdata <= mem[mem_address];
      end
    end
  end

  always @(negedge clk) begin
    if (host_readdatavalid === 1'b1) begin
      checks++;
      if (host_q.size() == 0) begin
        errors++; $display("FAIL host_unexpected_valid: got data %h, no read outstanding", host_readdata);
      end else begin
        logic [DW-1:0] e;
        e = host_q.pop_front();
        if (host_readdata !== e) begin
          errors++; $display("FAIL host_readdata: got %h expected %h", host_readdata, e);
        end
      end
    end
    if (disp_readdatavalid === 1'b1) begin
      checks++;
      if (disp_q.size() == 0) begin
        errors++; $display("FAIL disp_unexpected_valid: got data %h, no beat outstanding", disp_readdata);
      end else begin
        logic [DW-1:0] e;
        e = disp_q.pop_front();
        if (disp_readdata !== e) begin
          errors++; $display("FAIL disp_readdata: got %h expected %h", disp_readdata, e);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic push_burst(input logic [AW-1:0] addr, input int len);
    for (int i = 0; i < len; i++) begin
      logic [AW-1:0] a;
      a = addr + AW'(i);
      disp_q.push_back(model[a]);
    end
  endtask

  task automatic host_access(input logic wr, input logic [AW-1:0] a, input logic [BEW-1:0] be,
                             input logic [DW-1:0] d);
    int  n = 0;
    bit  granted = 0;
    host_address = a; host_byteenable = be; host_writedata = d;
    host_write = wr; host_read = !wr;
    while (!granted && n < 64) begin
      @(negedge clk);
      if (host_waitrequest === 1'b0) granted = 1;
      else begin next_cycle(); n++; end
    end
    checks++;
    if (!granted) begin
      errors++; $display("FAIL host_grant_timeout: waitrequest stuck at %b for addr %h", host_waitrequest, a);
    end else begin
      checks++;
      if (mem_address !== a || mem_chipselect !== 1'b1 || mem_write !== wr) begin
        errors++; $display("FAIL host_mem_drive: got addr %h cs %b we %b expected %h 1 %b",
                           mem_address, mem_chipselect, mem_write, a, wr);
      end
      if (wr) begin
        for (int b = 0; b < BEW; b++) if (be[b]) model[a][b*8 +: 8] = d[b*8 +: 8];
      end else begin
        host_q.push_back(model[a]);
      end
    end
    next_cycle();
    host_read = 1'b0; host_write = 1'b0;
    if (!wr && granted) begin
      @(negedge clk);
      checks++;
      if (host_readdatavalid !== 1'b1) begin
        errors++; $display("FAIL host_read_latency: valid %b one cycle after grant, expected 1", host_readdatavalid);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; disp_burst_req = 1'b1; host_read = 1'b1;
    next_cycle(); next_cycle();
    @(negedge clk);
    checks++; if (disp_burst_ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b expected 0", disp_burst_ack); end
    checks++; if (disp_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", disp_busy); end
    checks++; if (disp_readdatavalid !== 1'b0 || host_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL rst_valid: got %b/%b expected 0/0", disp_readdatavalid, host_readdatavalid); end
    checks++; if (mem_chipselect !== 1'b0 || mem_write !== 1'b0) begin
      errors++; $display("FAIL rst_mem_ctl: cs %b we %b expected 0 0", mem_chipselect, mem_write); end
    checks++; if (mem_clken !== 1'b0) begin errors++; $display("FAIL rst_clken: got %b expected 0", mem_clken); end
    checks++; if (host_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_waitreq: got %b expected 1", host_waitrequest); end
    next_cycle();
    reset = 1'b0; disp_burst_req = 1'b0; host_read = 1'b0;
    @(negedge clk);
    checks++; if (mem_clken !== 1'b1) begin errors++; $display("FAIL run_clken: got %b expected 1", mem_clken); end
    checks++; if (disp_busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", disp_busy); end
    next_cycle();
  endtask

  task automatic test_host_write_read();
    host_access(1'b1, 10'h3FF, 4'hF, 32'hDEADBEEF);
    host_access(1'b0, 10'h3FF, 4'hF, 32'h0);
  endtask

  task automatic test_burst_wrap();
    disp_burst_req = 1'b1; disp_burst_addr = 10'h3FE; disp_burst_len = 5'd4;
    @(negedge clk);
    checks++; if (disp_burst_ack !== 1'b1 || disp_busy !== 1'b1) begin
      errors++; $display("FAIL wrap_ack: ack %b busy %b expected 1 1", disp_burst_ack, disp_busy); end
    push_burst(10'h3FE, 4);
    next_cycle();
    disp_burst_req = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        logic [AW-1:0] ea;
        ea = 10'h3FE + AW'(k - 1);
        checks++;
        if (mem_address !== ea || mem_chipselect !== 1'b1 || mem_write !== 1'b0 || mem_byteenable !== 4'hF) begin
          errors++; $display("FAIL wrap_beat%0d: addr %h cs %b we %b be %h expected %h 1 0 f",
                             k, mem_address, mem_chipselect, mem_write, mem_byteenable, ea);
        end
      end
      checks++;
      if (disp_readdatavalid !== (k >= 2 && k <= 5)) begin
        errors++; $display("FAIL wrap_valid_T%0d: got %b expected %b", k, disp_readdatavalid, (k >= 2 && k <= 5));
      end
      checks++;
      if (disp_busy !== (k <= 4)) begin
        errors++; $display("FAIL wrap_busy_T%0d: got %b expected %b", k, disp_busy, (k <= 4));
      end
      next_cycle();
    end
  endtask

  task automatic test_tie();
    disp_burst_req = 1'b1; disp_burst_addr = 10'h010; disp_burst_len = 5'd3;
    host_write = 1'b1; host_address = 10'h020; host_byteenable = 4'hF; host_writedata = 32'h12345678;
    @(negedge clk);
    checks++; if (disp_burst_ack !== 1'b1 || host_waitrequest !== 1'b1) begin
      errors++; $display("FAIL tie_T: ack %b waitreq %b expected 1 1", disp_burst_ack, host_waitrequest); end
    push_burst(10'h010, 3);
    next_cycle();
    disp_burst_req = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (host_waitrequest !== (k <= 3)) begin
        errors++; $display("FAIL tie_waitreq_T%0d: got %b expected %b", k, host_waitrequest, (k <= 3));
      end
      if (k == 4) begin
        checks++;
        if (mem_write !== 1'b1 || mem_address !== 10'h020) begin
          errors++; $display("FAIL tie_commit: we %b addr %h expected 1 020", mem_write, mem_address);
        end
        model[10'h020] = 32'h12345678;
      end
      next_cycle();
    end
    host_write = 1'b0;
    host_access(1'b0, 10'h020, 4'hF, 32'h0);
  endtask

  task automatic test_byte_enable();
    host_access(1'b1, 10'h040, 4'hF, 32'hFFFFFFFF);
    host_access(1'b1, 10'h040, 4'b0010, 32'h00000000);
    host_access(1'b0, 10'h040, 4'hF, 32'h0);
  endtask

  task automatic test_reset_mid_burst();
    disp_burst_req = 1'b1; disp_burst_addr = 10'h100; disp_burst_len = 5'd8;
    @(negedge clk);
    checks++; if (disp_burst_ack !== 1'b1) begin errors++; $display("FAIL mid_ack: got %b expected 1", disp_burst_ack); end
    push_burst(10'h100, 8);
    next_cycle();
    disp_burst_req = 1'b0;
    next_cycle();
    reset = 1'b1; disp_burst_req = 1'b1;
    @(negedge clk);
    checks++; if (mem_chipselect !== 1'b0 || disp_burst_ack !== 1'b0) begin
      errors++; $display("FAIL mid_rst: cs %b ack %b expected 0 0", mem_chipselect, disp_burst_ack); end
    next_cycle();
    reset = 1'b0; disp_burst_addr = 10'h180; disp_burst_len = 5'd2;
    disp_q.delete();
    @(negedge clk);
    checks++; if (disp_burst_ack !== 1'b1 || mem_chipselect !== 1'b0) begin
      errors++; $display("FAIL mid_reack: ack %b cs %b expected 1 0", disp_burst_ack, mem_chipselect); end
    checks++; if (disp_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL mid_stale_valid: got %b expected 0", disp_readdatavalid); end
    push_burst(10'h180, 2);
    next_cycle();
    disp_burst_req = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (disp_readdatavalid !== (k == 2 || k == 3)) begin
        errors++; $display("FAIL mid_valid_T%0d: got %b expected %b", k, disp_readdatavalid, (k == 2 || k == 3));
      end
      if (k == 1) begin
        checks++;
        if (mem_address !== 10'h180) begin errors++; $display("FAIL mid_new_addr: got %h expected 180", mem_address); end
      end
      next_cycle();
    end
  endtask

  task automatic test_host_slot();
    int grant_cyc[$];
    int last_busy = 0;
`ifdef MEM_ARB_HOST_SLOT_EN
    int exp_g[$] = '{5, 10, 15};
    int exp_last = 19;
`else
    int exp_g[$] = '{17};
    int exp_last = 16;
`endif
    disp_burst_req = 1'b1; disp_burst_addr = 10'h200; disp_burst_len = 5'd16;
    host_read = 1'b1; host_address = 10'h300; host_byteenable = 4'hF;
    @(negedge clk);
    checks++; if (disp_burst_ack !== 1'b1 || host_waitrequest !== 1'b1) begin
      errors++; $display("FAIL slot_tie: ack %b waitreq %b expected 1 1", disp_burst_ack, host_waitrequest); end
    push_burst(10'h200, 16);
    next_cycle();
    disp_burst_req = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (disp_busy === 1'b1) last_busy = k;
      if (host_read && host_waitrequest === 1'b0) begin
        grant_cyc.push_back(k);
        host_q.push_back(model[10'h300]);
      end
      next_cycle();
      if (grant_cyc.size() >= exp_g.size()) host_read = 1'b0;
    end
    checks++;
    if (grant_cyc.size() != exp_g.size()) begin
      errors++; $display("FAIL slot_grant_count: got %0d expected %0d", grant_cyc.size(), exp_g.size());
    end else begin
      for (int i = 0; i < exp_g.size(); i++) begin
        checks++;
        if (grant_cyc[i] != exp_g[i]) begin
          errors++; $display("FAIL slot_grant%0d: at T+%0d expected T+%0d", i, grant_cyc[i], exp_g[i]);
        end
      end
    end
    checks++;
    if (last_busy != exp_last) begin
      errors++; $display("FAIL slot_burst_end: last busy T+%0d expected T+%0d", last_busy, exp_last);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) model[i] = 32'hC0DE0000 ^ (i * 32'h00010003);
    test_reset();
    test_host_write_read();
    test_burst_wrap();
    test_tie();
    test_byte_enable();
    test_reset_mid_burst();
    test_host_slot();
    repeat (4) next_cycle();
    checks++;
    if (host_q.size() != 0 || disp_q.size() != 0) begin
      errors++; $display("FAIL drain: %0d host and %0d display reads never returned", host_q.size(), disp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/onchip_mem_arbiter.md
# onchip_mem_arbiter

Sequencer and arbiter that shares the single-port 1024×32 on-chip memory between a display-fetch burst requester and a host Avalon-MM port. Display bursts are expanded into per-cycle incrementing reads. Host single-word reads and writes are interleaved whenever the memory is free. The block sits directly in front of the on-chip memory and owns all of its control inputs.

## Interface
- ADDR_W, 10, memory word-address width
- DATA_W, 32, data width
- BURST_W, 5, width of burst length (legal lengths 1..16)
- HOST_SLOT_PERIOD, 4, burst beats between host slots (used only with macro)

- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- disp_burst_req  in  1  burst request, level
- disp_burst_addr  in  ADDR_W  first word address
- disp_burst_len  in  BURST_W  beat count; 0 treated as 1
- disp_burst_ack  out  1  one-cycle pulse: burst accepted, addr/len latched
- disp_busy  out  1  high from ack through last beat
- disp_readdata  out  DATA_W  read data
- disp_readdatavalid  out  1  one pulse per beat
- host_address  in  ADDR_W  word address
- host_byteenable  in  DATA_W/8  write byte lanes
- host_read, host_write  in  1  access strobes; if both high, treated as write
- host_writedata  in  DATA_W
- host_waitrequest  out  1  combinational stall
- host_readdata  out  DATA_W
- host_readdatavalid  out  1
- mem_address  out  ADDR_W
- mem_byteenable  out  DATA_W/8
- mem_chipselect, mem_write, mem_clken  out  1
- mem_writedata  out  DATA_W
- mem_readdata  in  DATA_W  valid one cycle after address

## Operation
- States: IDLE, BURST.
- IDLE, disp_burst_req=1:
  - Pulse ack; latch addr and len (0→1); go to BURST.
  - No memory access this cycle; host stalls.
- IDLE, no display request, host strobe=1:
  - Grant host; host_waitrequest=0 in the same cycle.
  - Drive mem_* from host port; mem_chipselect=1; mem_write=host_write.
- BURST, each cycle:
  - Issue a read at the beat address with byteenable all-ones.
  - Address increments modulo 2^ADDR_W; wraps 0x3FF→0x000.
  - Remaining count decrements; the last beat returns the state to IDLE.
- BURST: host_waitrequest=1 whenever a host strobe is high.
- disp_burst_req during BURST is ignored; no ack is issued until the block is back in IDLE.
- Read return:
  - A 1-bit owner/valid register tags each issued read.
  - The next cycle, mem_readdata routes to both readdata outputs; only the owner's valid is asserted.
- Writes produce no valid.
- mem_clken=1 except during reset.

## Timing
- Reset values:
  - State IDLE; counters 0.
  - disp_burst_ack=0, disp_busy=0, both readdatavalid=0.
  - mem_chipselect=0, mem_write=0, mem_clken=0.
  - host_waitrequest=1 while reset is high.
- Burst of N accepted at cycle T: beats issue at T+1..T+N, and valids appear at T+2..T+N+1 on consecutive cycles.
- The earliest next ack is T+N+1. A host access may also take T+N+1, but display wins any tie in IDLE.
- Host read: grant at cycle G, readdatavalid at G+1. Host write commits at the G clock edge.
- Reset mid-burst aborts the burst. Starting the cycle after reset is sampled: no further valids, no pending grants.

## Configuration
- MEM_ARB_HOST_SLOT_EN defined:
  - In BURST, after HOST_SLOT_PERIOD consecutive beats with a host strobe pending, the next cycle goes to the host.
  - During that slot the beat address and count hold. The period counter clears on the host slot and when the burst ends.
  - The burst lengthens by the number of slots taken.
- MEM_ARB_HOST_SLOT_EN undefined: bursts are never interrupted and the period counter is absent.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, BURST);
  - ADDR_W/DATA_W/BURST_W defaults;
  - BYTE_EN_ALL constant;
  - the owner encoding (OWN_DISP, OWN_HOST).
- One sub-module, mem_arb_burst_ctr: loadable address incrementer plus remaining-beat down-counter, with hold input and last-beat flag.

## Test plan
- Host write 0x3FF←0xDEADBEEF with be=4'hF, then read 0x3FF → waitrequest=0 in the grant cycle; host_readdatavalid one cycle later with 0xDEADBEEF.
- Burst addr=0x3FE, len=4 → mem_address 3FE,3FF,000,001 on T+1..T+4; disp_readdatavalid on T+2..T+5; disp_busy falls after T+4.
- disp_burst_req and host_write arrive simultaneously in IDLE, len=3 → ack at T; host_waitrequest=1 at T..T+3; write commits at T+4.
- Preload 0xFFFFFFFF, host write 0x00000000 with be=4'b0010, then read → 0xFFFF00FF.
- Reset high during beat 2 of a len=8 burst → no disp_readdatavalid afterwards, mem_chipselect=0, state IDLE; a new request is acked the first cycle after reset drops.
- With MEM_ARB_HOST_SLOT_EN, len=16 burst with host_read held → host grants after beats 4, 8 and 12 (3 host valids); 16 display valids; burst ends at T+19.
